ping_sequencer: RTL

- Measurement-cycle controller for the sonar datapath.
- Schedules each ping period in order: transmit burst, blanking (ring-down) window, listen window, then hold to period end.
- Gates the transmit beamformer, issues the per-ping clear pulse to the receive, ToF and velocity paths, and debounces the echo comparator.
- Reports time-of-flight in clock cycles, or a timeout when no echo is confirmed.

---
 rtl/ping_sequencer_if.sv | 24 ++
 rtl/ping_sequencer.sv | 75 +++++++
 2 files changed

// File: rtl/ping_sequencer_if.sv
// ping_sequencer_if: control and result signals between the ping sequencer and the sonar datapath
// master: drives enable_in and echo_detected_in, observes the sequencer outputs
// slave: the sequencer side
interface ping_sequencer_if;
    logic        enable_in;
    logic        echo_detected_in;
    logic        tx_enable_out;
    logic        burst_start_out;
    logic        listen_out;
    logic        busy_out;
    logic [23:0] tof_cycles_out;
    logic        tof_valid_out;
    logic        timeout_out;
    modport master (
        output enable_in, echo_detected_in,
        input  tx_enable_out, burst_start_out, listen_out, busy_out,
               tof_cycles_out, tof_valid_out, timeout_out
    );
    modport slave (
        input  enable_in, echo_detected_in,
        output tx_enable_out, burst_start_out, listen_out, busy_out,
               tof_cycles_out, tof_valid_out, timeout_out
    );
endinterface

// File: rtl/ping_sequencer.sv
// ping_sequencer: sonar ping scheduler (burst, blanking, listen, hold) with echo debounce and time-of-flight report
// clk_in, rst_in (sync, active high); bus: enable/echo in, tx gate, burst-start clear, listen, busy, tof result/timeout out
module ping_sequencer #(
    parameter int PERIOD_CYCLES = 16777216,
    parameter int BURST_CYCLES  = 524288,
    parameter int BLANK_CYCLES  = 65536,
    parameter int LISTEN_CYCLES = 8388608,
    parameter int ECHO_CONFIRM  = 4
) (
    input logic clk_in,
    input logic rst_in,
    ping_sequencer_if.slave bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] BURST  = 3'd1;
    localparam logic [2:0] BLANK  = 3'd2;
    localparam logic [2:0] LISTEN = 3'd3;
    localparam logic [2:0] HOLD   = 3'd4;
    localparam int RW = $clog2(ECHO_CONFIRM + 1);
    localparam logic [RW-1:0] CONF   = RW'(ECHO_CONFIRM);
    localparam logic [23:0]   CONF24 = 24'(ECHO_CONFIRM);
    localparam logic [23:0]   B_END  = 24'(BURST_CYCLES - 1);
    localparam logic [23:0]   K_END  = 24'(BURST_CYCLES + BLANK_CYCLES - 1);
    localparam logic [23:0]   L_END  = 24'(BURST_CYCLES + BLANK_CYCLES + LISTEN_CYCLES - 1);
    localparam logic [23:0]   P_END  = 24'(PERIOD_CYCLES - 1);
    logic [2:0]    state, state_nx;
    logic [23:0]   cnt, cnt_nx;
    logic [RW-1:0] run, run_nx;
    logic          hit, expire, last;
    always_comb begin
        // run only accumulates inside LISTEN, so blanking samples never count
        run_nx = (state == LISTEN && bus.echo_detected_in) ? run + 1'b1 : '0;
        hit    = state == LISTEN && run_nx == CONF;
        // a confirmation on the final listen sample wins over the timeout
        expire = state == LISTEN && !hit && cnt == L_END;
        last   = cnt == P_END;
        cnt_nx = (state == IDLE || (state == HOLD && last)) ? '0 : cnt + 24'd1;
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.enable_in ? BURST : IDLE;
            BURST:   state_nx = cnt == B_END ? BLANK : BURST;
            BLANK:   state_nx = cnt == K_END ? LISTEN : BLANK;
            LISTEN:  state_nx = (hit || expire) ? HOLD : LISTEN;
            HOLD:    state_nx = last ? (bus.enable_in ? BURST : IDLE) : HOLD;
            default: state_nx = IDLE;
        endcase
    end
    // outputs are registered from the next-state values so they line up with the state they describe
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state               <= IDLE;
            cnt                 <= '0;
            run                 <= '0;
            bus.tx_enable_out   <= 1'b0;
            bus.burst_start_out <= 1'b0;
            bus.listen_out      <= 1'b0;
            bus.busy_out        <= 1'b0;
            bus.tof_cycles_out  <= '0;
            bus.tof_valid_out   <= 1'b0;
            bus.timeout_out     <= 1'b0;
        end else begin
            state               <= state_nx;
            cnt                 <= cnt_nx;
            run                 <= run_nx;
            bus.tx_enable_out   <= state_nx == BURST;
            bus.burst_start_out <= state_nx == BURST && cnt_nx == '0;
            bus.listen_out      <= state_nx == LISTEN;
            bus.busy_out        <= state_nx != IDLE;
            bus.tof_valid_out   <= hit;
            bus.timeout_out     <= expire;
            // the run began ECHO_CONFIRM samples before the cycle that follows this one
            if (hit) bus.tof_cycles_out <= cnt + 24'd1 - CONF24;
        end
    end
endmodule
